// File: rtl/paddle.sv
`default_nettype none
//==============================================================================
// Module   : paddle
// Purpose  : Debounced, auto-repeating paddle row position from two raw
//            buttons. Define PADDLE_WRAP_EN to wrap at the edges instead of
//            clamping.
// Revision : 1.0 - initial release
//==============================================================================
module paddle #(
    parameter int DEBOUNCE     = 20,
    parameter int REPEAT_DELAY = 250,
    parameter int REPEAT_RATE  = 60,
    parameter int LENGTH       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] y,
    output logic       moving
);

    localparam logic [1:0] c_cmd_none  = 2'd0;
    localparam logic [1:0] c_cmd_up    = 2'd1;
    localparam logic [1:0] c_cmd_down  = 2'd2;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_hold   = 2'd1;
    localparam logic [1:0] c_st_repeat = 2'd2;

    localparam logic [4:0] c_y_max     = 5'(16 - LENGTH);
    localparam logic [4:0] c_y_ctr     = 5'((16 - LENGTH) / 2);
    localparam logic [7:0] c_deb       = 8'(DEBOUNCE);
    localparam logic [9:0] c_delay     = 10'(REPEAT_DELAY);
    localparam logic [9:0] c_rate      = 10'(REPEAT_RATE);

    logic [1:0] w_raw;
    logic [1:0] w_deb;
    logic [1:0] w_cmd;

    logic [1:0] r_state;
    logic [1:0] r_dir;
    logic [9:0] r_rc;
    logic [4:0] r_y;
    logic       r_moving;

    logic [1:0] w_state_nxt;
    logic [1:0] w_dir_nxt;
    logic [9:0] w_rc_nxt;
    logic [9:0] w_rc_inc;
    logic [9:0] w_rc_lim;
    logic       w_step;
    logic [4:0] w_y_nxt;
    logic       w_move_nxt;

    assign w_raw = {btn_down, btn_up};

    // Bit 0 is the up button, bit 1 the down button.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [1:0] r_sync;
        logic [7:0] r_cnt;
        logic       r_deb;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= 2'b00;
                r_cnt  <= 8'd0;
                r_deb  <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], w_raw[i]};
                if (tick) begin
                    if (r_sync[1] != r_deb) begin
                        if (r_cnt == c_deb - 8'd1) begin
                            r_deb <= r_sync[1];
                            r_cnt <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end else begin
                        r_cnt <= 8'd0;
                    end
                end
            end
        end

        assign w_deb[i] = r_deb;
    end

    always_comb begin
        w_cmd = c_cmd_none;
        if (w_deb == 2'b01) begin
            w_cmd = c_cmd_up;
        end else if (w_deb == 2'b10) begin
            w_cmd = c_cmd_down;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_dir    <= c_cmd_none;
            r_rc     <= 10'd0;
            r_y      <= c_y_ctr;
            r_moving <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir    <= w_dir_nxt;
            r_rc     <= w_rc_nxt;
            r_y      <= w_y_nxt;
            r_moving <= w_move_nxt;
        end
    end

    assign w_rc_inc = r_rc + 10'd1;
    assign w_rc_lim = (r_state == c_st_hold) ? c_delay : c_rate;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_rc_nxt    = r_rc;
        w_step      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_cmd != c_cmd_none) begin
                    w_step      = 1'b1;
                    w_dir_nxt   = w_cmd;
                    w_rc_nxt    = 10'd0;
                    w_state_nxt = c_st_hold;
                end
            end
            c_st_hold, c_st_repeat: begin
                if (w_cmd == c_cmd_none) begin
                    w_rc_nxt    = 10'd0;
                    w_state_nxt = c_st_idle;
                end else if (w_cmd != r_dir) begin
                    // Opposite direction behaves like a fresh press.
                    w_step      = 1'b1;
                    w_dir_nxt   = w_cmd;
                    w_rc_nxt    = 10'd0;
                    w_state_nxt = c_st_hold;
                end else if (tick) begin
                    if (w_rc_inc == w_rc_lim) begin
                        w_step      = 1'b1;
                        w_rc_nxt    = 10'd0;
                        w_state_nxt = c_st_repeat;
                    end else begin
                        w_rc_nxt = w_rc_inc;
                    end
                end
            end
            default: begin
                w_rc_nxt    = 10'd0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Position stays 5 bits wide so the range checks never see a 4-bit wrap.
    always_comb begin
        w_y_nxt    = r_y;
        w_move_nxt = 1'b0;
        if (w_step) begin
            if (w_dir_nxt == c_cmd_up) begin
                if (r_y != 5'd0) begin
                    w_y_nxt    = r_y - 5'd1;
                    w_move_nxt = 1'b1;
                end else begin
`ifdef PADDLE_WRAP_EN
                    w_y_nxt    = c_y_max;
                    w_move_nxt = 1'b1;
`else
                    w_y_nxt    = r_y;
`endif
                end
            end else begin
                if (r_y + 5'd1 <= c_y_max) begin
                    w_y_nxt    = r_y + 5'd1;
                    w_move_nxt = 1'b1;
                end else begin
`ifdef PADDLE_WRAP_EN
                    w_y_nxt    = 5'd0;
                    w_move_nxt = 1'b1;
`else
                    w_y_nxt    = r_y;
`endif
                end
            end
        end
    end

    assign y      = r_y[3:0];
    assign moving = r_moving;

endmodule
`default_nettype wire
